// File: rtl/serial_mac62.sv
// Sequential signed-magnitude multiply-accumulate over an N-element vector pair,
// one product per clock, producing the 21-bit sign/magnitude neuron operand.
module serial_mac62 #(
  parameter int N = 62
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*8-1:0] in_vec,
  input  logic [N*8-1:0] w_vec,
  output logic           busy,
  output logic           done,
  output logic [20:0]    out
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N*8-1:0]  r_in;
  logic [N*8-1:0]  r_w;
  logic [IW-1:0]   r_idx;
  logic [20:0]     r_acc;
  logic [20:0]     r_out;
  logic            r_busy;
  logic            r_done;

  logic [7:0]      w_a;
  logic [7:0]      w_b;
  logic [13:0]     w_pmag;
  logic            w_psign;
  logic [20:0]     w_sum;
  logic            w_load;
  logic            w_last;

  // Signed-magnitude add; a zero result is always returned as +0.
  function automatic logic [20:0] sm_add(input logic [20:0] acc,
                                         input logic        p_sign,
                                         input logic [13:0] p_mag);
    logic [19:0] a_mag;
    logic [19:0] b_mag;
    logic [19:0] s_mag;
    logic        s_sign;
    a_mag = acc[19:0];
    b_mag = {6'd0, p_mag};
    if (b_mag == 20'd0) begin
      s_sign = acc[20];
      s_mag  = a_mag;
    end else if (acc[20] == p_sign) begin
      s_sign = acc[20];
      s_mag  = a_mag + b_mag;
    end else if (a_mag > b_mag) begin
      s_sign = acc[20];
      s_mag  = a_mag - b_mag;
    end else if (b_mag > a_mag) begin
      s_sign = p_sign;
      s_mag  = b_mag - a_mag;
    end else begin
      s_sign = 1'b0;
      s_mag  = 20'd0;
    end
    return {s_sign & (s_mag != 20'd0), s_mag};
  endfunction

  // Single shared multiplier and adder on the currently indexed element.
  always_comb begin
    w_a     = r_in[{r_idx, 3'b000} +: 8];
    w_b     = r_w[{r_idx, 3'b000} +: 8];
    w_psign = w_a[7] ^ w_b[7];
    w_pmag  = {7'd0, w_a[6:0]} * {7'd0, w_b[6:0]};
    w_sum   = sm_add(r_acc, w_psign, w_pmag);
    w_load  = start && (r_state != S_ACCUM);
    w_last  = (r_idx == LAST_IDX);
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ACCUM;
        else       w_next = S_IDLE;
      end
      S_ACCUM: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_ACCUM;
      end
      S_DONE: begin
        if (start) w_next = S_ACCUM;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Busy/done are registered decodes of the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == S_ACCUM);
      r_done <= (w_next == S_DONE);
    end
  end

  // Operand capture, accumulation and result update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in  <= {(N*8){1'b0}};
      r_w   <= {(N*8){1'b0}};
      r_idx <= {IW{1'b0}};
      r_acc <= 21'd0;
      r_out <= 21'd0;
    end else if (w_load) begin
      r_in  <= in_vec;
      r_w   <= w_vec;
      r_idx <= {IW{1'b0}};
      r_acc <= 21'd0;
    end else if (r_state == S_ACCUM) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_idx <= {IW{1'b0}};
        r_out <= w_sum;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;

endmodule

// File: tb/tb_serial_mac62.sv
// Directed self-checking bench for serial_mac62 with hand-computed results.
module tb_serial_mac62;

  localparam int N = 62;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N*8-1:0] in_vec;
  logic [N*8-1:0] w_vec;
  logic           busy;
  logic           done;
  logic [20:0]    out;

  int total;
  int bad;

  serial_mac62 #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in_vec (in_vec),
    .w_vec  (w_vec),
    .busy   (busy),
    .done   (done),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*8-1:0] fill(input logic [7:0] b);
    logic [N*8-1:0] f;
    for (int i = 0; i < N; i++) f[i*8 +: 8] = b;
    return f;
  endfunction

  // Pulse start for one edge and wait (bounded) for done.
  task automatic run_vec(input logic [N*8-1:0] iv, input logic [N*8-1:0] wv,
                         output int cyc, output int bcnt);
    in_vec = iv;
    w_vec  = wv;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    cyc    = 0;
    bcnt   = busy ? 1 : 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_vec = '0; w_vec = '0;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (out !== 21'h000000) begin bad++; $display("FAIL reset_out got=%h exp=000000", out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ones();
    int cyc, bcnt;
    run_vec(fill(8'h01), fill(8'h01), cyc, bcnt);
    total++; if (cyc != 62) begin bad++; $display("FAIL ones_latency got=%0d exp=62", cyc); end
    total++; if (bcnt != 62) begin bad++; $display("FAIL ones_busy_cycles got=%0d exp=62", bcnt); end
    total++; if (out !== 21'h00003E) begin bad++; $display("FAIL ones_out got=%h exp=00003e", out); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ones_done_pulse got=%b exp=0", done); end
    repeat (3) tick();
    total++; if (out !== 21'h00003E) begin bad++; $display("FAIL ones_out_hold got=%h exp=00003e", out); end
  endtask

  task automatic test_max();
    int cyc, bcnt;
    run_vec(fill(8'h7F), fill(8'h7F), cyc, bcnt);
    total++; if (out !== 21'h0F423E) begin bad++; $display("FAIL max_pos_out got=%h exp=0f423e", out); end
    tick();
    run_vec(fill(8'h7F), fill(8'hFF), cyc, bcnt);
    total++; if (out !== 21'h1F423E) begin bad++; $display("FAIL max_neg_out got=%h exp=1f423e", out); end
    tick();
  endtask

  task automatic test_neg_zero();
    int cyc, bcnt;
    run_vec(fill(8'h80), fill(8'h80), cyc, bcnt);
    total++; if (out !== 21'h000000) begin bad++; $display("FAIL negzero_out got=%h exp=000000", out); end
    tick();
  endtask

  task automatic test_crossover();
    int cyc, bcnt;
    logic [N*8-1:0] iv;
    iv = '0;
    iv[7:0]  = 8'h8A;
    iv[15:8] = 8'h04;
    run_vec(iv, fill(8'h01), cyc, bcnt);
    total++; if (out !== 21'h100006) begin bad++; $display("FAIL crossover_out got=%h exp=100006", out); end
    tick();
  endtask

  task automatic test_cancel();
    int cyc, bcnt;
    logic [N*8-1:0] wv;
    for (int i = 0; i < N; i++) wv[i*8 +: 8] = (i % 2 == 0) ? 8'h03 : 8'h83;
    run_vec(fill(8'h05), wv, cyc, bcnt);
    total++; if (out !== 21'h000000) begin bad++; $display("FAIL cancel_out got=%h exp=000000", out); end
    tick();
  endtask

  task automatic test_start_ignored();
    int cyc, ndone, nbusy;
    in_vec = fill(8'h01);
    w_vec  = fill(8'h01);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    in_vec = fill(8'h7F);
    w_vec  = fill(8'h7F);
    cyc = 0;
    while (!done && cyc < 200) begin
      start = (cyc == 9);
      tick();
      cyc++;
    end
    start = 1'b0;
    total++; if (cyc != 62) begin bad++; $display("FAIL ign_latency got=%0d exp=62", cyc); end
    total++; if (out !== 21'h00003E) begin bad++; $display("FAIL ign_out got=%h exp=00003e", out); end
    ndone = 0; nbusy = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (done) ndone++;
      if (busy) nbusy++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL ign_extra_done got=%0d exp=0", ndone); end
    total++; if (nbusy != 0) begin bad++; $display("FAIL ign_extra_busy got=%0d exp=0", nbusy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    in_vec = fill(8'h01);
    w_vec  = fill(8'h01);
    start  = 1'b1;
    tick();
    cyc = 0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    total++; if (cyc != 62) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=62", cyc); end
    total++; if (out !== 21'h00003E) begin bad++; $display("FAIL b2b_first_out got=%h exp=00003e", out); end
    in_vec = fill(8'h02);
    tick();
    cyc = 1;
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got=done%b/busy%b exp=done0/busy1", done, busy); end
    while (!done && cyc < 200) begin tick(); cyc++; end
    start = 1'b0;
    total++; if (cyc != 63) begin bad++; $display("FAIL b2b_spacing got=%0d exp=63", cyc); end
    total++; if (out !== 21'h00007C) begin bad++; $display("FAIL b2b_second_out got=%h exp=00007c", out); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=done%b/busy%b exp=done0/busy0", done, busy); end
  endtask

  task automatic test_reset_abort();
    int cyc, bcnt, ndone;
    in_vec = fill(8'h7F);
    w_vec  = fill(8'h7F);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    total++; if (out !== 21'h000000) begin bad++; $display("FAIL abort_out got=%h exp=000000", out); end
    tick(); tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (done) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL abort_late_done got=%0d exp=0", ndone); end
    run_vec(fill(8'h7F), fill(8'h7F), cyc, bcnt);
    total++; if (cyc != 62) begin bad++; $display("FAIL abort_rerun_latency got=%0d exp=62", cyc); end
    total++; if (out !== 21'h0F423E) begin bad++; $display("FAIL abort_rerun_out got=%h exp=0f423e", out); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ones();
    test_max();
    test_neg_zero();
    test_crossover();
    test_cancel();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
